// File: rtl/y_deskew_collector.sv
// Removes the diagonal skew from the systolic array's result stream, buffers one
// N x N matrix and drains it as row-aligned packed rows over valid/ready.
module y_deskew_collector #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [W*N-1:0] y_in,
  input  logic           y_valid,
  output logic [W*N-1:0] out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           out_last,
  output logic           busy,
  output logic           done,
  output logic           overrun
);

  localparam int unsigned CW    = (2 * N - 1 > 1) ? $clog2(2 * N - 1) : 1;
  localparam int unsigned RW    = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CLAST = 2 * N - 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n, cur_c;
  logic [RW-1:0]   rd, rd_n;
  logic            wr_en;
  logic            done_n;
  logic [W*N-1:0]  row_n;
  logic [W-1:0]    mem [N][N];

  // Next-state, counters and write strobe.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rd_n    = rd;
    cur_c   = cnt;
    wr_en   = 1'b0;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (y_valid) begin
          wr_en   = 1'b1;
          cur_c   = '0;
          cnt_n   = CW'(1);
          rd_n    = '0;
          state_n = (N == 1) ? DRAIN : CAPTURE;
        end
      end
      CAPTURE: begin
        if (y_valid) begin
          wr_en = 1'b1;
          cnt_n = cnt + CW'(1);
          if (cnt == CW'(CLAST)) begin
            state_n = DRAIN;
            rd_n    = '0;
          end
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (rd == RW'(N - 1)) begin
            state_n = IDLE;
            done_n  = 1'b1;
            rd_n    = '0;
            cnt_n   = '0;
          end else begin
            rd_n = rd + RW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Row about to be presented, forwarding any element written on this same edge.
  always_comb begin
    row_n = '0;
    for (int i = 0; i < int'(N); i++) begin
      row_n[W*i +: W] = mem[rd_n][i];
      if (wr_en && (cur_c == CW'(int'(rd_n) + i)))
        row_n[W*i +: W] = y_in[W*i +: W];
    end
  end

  // Lane i on valid cycle c holds element k = c - i.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      for (int k = 0; k < int'(N); k++) begin
        for (int i = 0; i < int'(N); i++) begin
          if (cur_c == CW'(k + i))
            mem[k][i] <= y_in[W*i +: W];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rd        <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      rd        <= rd_n;
      out_valid <= (state_n == DRAIN);
      out_last  <= (state_n == DRAIN) && (rd_n == RW'(N - 1));
      busy      <= (state_n != IDLE);
      done      <= done_n;
      if (state == DRAIN && y_valid)
        overrun <= 1'b1;
      if (state_n == DRAIN)
        out_data <= row_n;
    end
  end

endmodule

// File: tb/tb_y_deskew_collector.sv
// Bench for y_deskew_collector: scenario table plus randomized matrices checked
// against a matrix-level model of the deskew and drain behaviour.
module tb_y_deskew_collector;

  localparam int unsigned N = 4;
  localparam int unsigned W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [W*N-1:0] y_in;
  logic           y_valid;
  logic [W*N-1:0] out_data;
  logic           out_valid;
  logic           out_ready;
  logic           out_last;
  logic           busy;
  logic           done;
  logic           overrun;

  always #5 clk = ~clk;

  y_deskew_collector #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .y_in      (y_in),
    .y_valid   (y_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .overrun   (overrun)
  );

  int checks = 0;
  int passes = 0;

  logic [7:0]  m [4][4];
  bit          ovr_exp = 1'b0;
  logic [31:0] got_rows [$];
  bit          got_last [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Output monitor: collects accepted rows, checks hold-under-stall and done timing.
  bit          prev_stall = 1'b0;
  bit          prev_last_acc = 1'b0;
  logic [31:0] prev_data = '0;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall    = 1'b0;
      prev_last_acc = 1'b0;
      got_rows.delete();
      got_last.delete();
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", out_data, prev_data);
      end
      if (done || prev_last_acc) chk("done_align", 32'(done), 32'(prev_last_acc));
      if (out_last) chk("last_without_valid", 32'(out_valid), 32'd1);
      if (out_valid && out_ready) begin
        got_rows.push_back(out_data);
        got_last.push_back(out_last);
      end
      prev_stall    = out_valid && !out_ready;
      prev_data     = out_data;
      prev_last_acc = out_valid && out_ready && out_last;
    end
  end

  task automatic set_basic();
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 4; i++) m[k][i] = 8'(10 * k + i);
  endtask

  task automatic set_random();
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 4; i++) m[k][i] = 8'($urandom_range(0, 254));
  endtask

  // Drive one skewed valid cycle c from matrix m (out-of-range lanes carry 0xFF).
  task automatic drive_cycle(input int c);
    y_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c - i >= 0 && c - i <= 3) y_in[8*i +: 8] = m[c-i][i];
      else y_in[8*i +: 8] = 8'hFF;
    end
    @(posedge clk); #1;
  endtask

  task automatic run_matrix(input bit idle_before, input logic [6:0] gaps,
                            input logic [3:0] rp, input bit inj);
    bit          acc_last;
    logic [31:0] exp_row;
    if (idle_before) begin
      y_valid = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
    end else begin
      chk("b2b_start_on_done", 32'(done), 32'd1);
    end
    got_rows.delete();
    got_last.delete();
    for (int c = 0; c < 7; c++) begin
      if (gaps[c]) begin
        y_valid = 1'b0;
        y_in    = $urandom;
        @(posedge clk); #1;
      end
      drive_cycle(c);
    end
    y_valid  = 1'b0;
    acc_last = 1'b0;
    for (int j = 0; j < 64 && !acc_last; j++) begin
      out_ready = rp[j % 4];
      y_valid   = inj && (j == 1);
      y_in      = $urandom;
      @(negedge clk);
      if (j == 0) chk("latency_valid", 32'(out_valid), 32'd1);
      acc_last = out_valid && out_ready && out_last;
      @(posedge clk); #1;
    end
    y_valid   = 1'b0;
    out_ready = 1'b0;
    if (!acc_last) chk("drain_timeout", 32'd0, 32'd1);
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_on_done", 32'(busy), 32'd0);
    if (inj) ovr_exp = 1'b1;
    chk("overrun", 32'(overrun), 32'(ovr_exp));
    chk("row_count", 32'(got_rows.size()), 32'd4);
    for (int r = 0; r < 4; r++) begin
      if (r < got_rows.size()) begin
        for (int i = 0; i < 4; i++) exp_row[8*i +: 8] = m[r][i];
        chk($sformatf("row%0d_data", r), got_rows[r], exp_row);
        chk($sformatf("row%0d_last", r), 32'(got_last[r]), 32'(r == 3));
      end
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_last"}, 32'(out_last), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_overrun"}, 32'(overrun), 32'd0);
    chk({tag, "_out_data"}, out_data, 32'd0);
  endtask

  typedef struct {
    bit         rand_mat;
    bit         idle_before;
    logic [6:0] gaps;
    logic [3:0] ready_pat;
    bit         inj;
    bit         exp_ovr;
  } vec_t;

  vec_t tbl [6];

  initial begin
    tbl[0] = '{1'b0, 1'b1, 7'b0000000, 4'b1111, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 7'b0100100, 4'b1111, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 7'b0000000, 4'b1001, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 7'b0000000, 4'b1111, 1'b1, 1'b1};
    tbl[4] = '{1'b1, 1'b0, 7'($urandom), 4'($urandom) | 4'b0001, 1'b0, 1'b1};
    tbl[5] = '{1'b1, 1'b0, 7'b0000000, 4'b1111, 1'b0, 1'b1};

    rst       = 1'b1;
    y_valid   = 1'b0;
    y_in      = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("por");
    @(posedge clk); #1;
    rst = 1'b0;

    for (int v = 0; v < 6; v++) begin
      if (tbl[v].rand_mat) set_random();
      else set_basic();
      run_matrix(tbl[v].idle_before, tbl[v].gaps, tbl[v].ready_pat, tbl[v].inj);
      chk($sformatf("vec%0d_overrun", v), 32'(overrun), 32'(tbl[v].exp_ovr));
      if (v == 0 && got_rows.size() > 2) chk("basic_row2", got_rows[2], 32'h1716_1514);
    end

    // Reset after three capture cycles abandons the partial matrix.
    y_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    set_basic();
    for (int c = 0; c < 3; c++) drive_cycle(c);
    chk("busy_mid_capture", 32'(busy), 32'd1);
    rst     = 1'b1;
    y_valid = 1'b1;
    y_in    = $urandom;
    @(posedge clk); #1;
    @(negedge clk);
    chk_reset_outputs("midrst");
    @(posedge clk); #1;
    rst     = 1'b0;
    y_valid = 1'b0;
    ovr_exp = 1'b0;
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 4; i++) m[k][i] = 8'(100 + k * 4 + i);
    run_matrix(1'b1, 7'b0000000, 4'b1111, 1'b0);

    // Randomized back-to-back and idle-separated matrices.
    for (int t = 0; t < 8; t++) begin
      set_random();
      run_matrix(1'($urandom), 7'($urandom), 4'($urandom) | 4'b0001, (t == 5));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
